// File: rtl/sfifo_pkg.sv
// Shared constants and level-compare helpers for the single-clock FIFO family.
package sfifo_pkg;

    localparam int unsigned SFIFO_DEF_DATA_WIDTH = 8;
    localparam int unsigned SFIFO_DEF_ADDR_WIDTH = 4;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

    function automatic logic lvl_le(input logic [31:0] lvl, input logic [31:0] thr);
        return (lvl <= thr);
    endfunction

    function automatic logic lvl_ge(input logic [31:0] lvl, input logic [31:0] thr);
        return (lvl >= thr);
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// FIFO storage: DEPTH x DATA_WIDTH array, synchronous write, asynchronous read.
module sfifo_ram
    import sfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SFIFO_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SFIFO_DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sfifo_lvl.sv
// Single-clock FIFO with exact fill level, programmable almost flags and sticky errors.
// Define SFIFO_FWFT_EN for first-word-fall-through; default is a registered 1-cycle read path.
module sfifo_lvl
    import sfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SFIFO_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SFIFO_DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_winc,
    input  logic                  i_rinc,
    input  logic [ADDR_WIDTH-1:0] i_aempty_thr,
    input  logic [ADDR_WIDTH-1:0] i_afull_thr,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_wfull,
    output logic                  o_wfull_almost,
    output logic                  o_rempty,
    output logic                  o_rempty_almost,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_level;
    logic                  r_wfull;
    logic                  r_wfull_almost;
    logic                  r_rempty;
    logic                  r_rempty_almost;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [PW-1:0]         w_wptr_nxt;
    logic [PW-1:0]         w_rptr_nxt;
    logic [PW-1:0]         w_level_nxt;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_wr_acc    = i_winc & ~r_wfull;
    assign w_rd_acc    = i_rinc & ~r_rempty;
    assign w_wptr_nxt  = r_wptr + PW'(w_wr_acc);
    assign w_rptr_nxt  = r_rptr + PW'(w_rd_acc);
    assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

    // A write dropped at full stays silent when a read frees a slot in the same cycle.
    assign w_ovf_set   = i_winc & r_wfull & ~i_rinc;
    assign w_udf_set   = i_rinc & r_rempty;

    sfifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_acc & ~i_rst),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata (i_wdata),
        .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // Pointers and status flags, all registered from the next-state level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_level         <= '0;
            r_wfull         <= 1'b0;
            r_wfull_almost  <= 1'b0;
            r_rempty        <= 1'b1;
            r_rempty_almost <= 1'b1;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else begin
            r_wptr          <= w_wptr_nxt;
            r_rptr          <= w_rptr_nxt;
            r_level         <= w_level_nxt;
            r_wfull         <= (w_level_nxt == PW'(DEPTH));
            r_rempty        <= (w_level_nxt == '0);
            r_wfull_almost  <= lvl_ge(32'(w_level_nxt), 32'(DEPTH) - 32'(i_afull_thr));
            r_rempty_almost <= lvl_le(32'(w_level_nxt), 32'(i_aempty_thr));
            r_overflow      <= (r_overflow & ~i_clr_err) | w_ovf_set;
            r_underflow     <= (r_underflow & ~i_clr_err) | w_udf_set;
        end
    end

`ifdef SFIFO_FWFT_EN
    assign o_rdata  = w_ram_rdata;
    assign o_rvalid = ~r_rempty;
`else
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rdata <= w_ram_rdata;
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
`endif

    assign o_wfull         = r_wfull;
    assign o_wfull_almost  = r_wfull_almost;
    assign o_rempty        = r_rempty;
    assign o_rempty_almost = r_rempty_almost;
    assign o_level         = r_level;
    assign o_overflow      = r_overflow;
    assign o_underflow     = r_underflow;

endmodule

// File: tb/tb_sfifo_lvl.sv
// Directed bench for sfifo_lvl (DEPTH 16, thresholds 3); FWFT steps follow SFIFO_FWFT_EN.
module tb_sfifo_lvl;

    logic       clk;
    logic       rst;
    logic [7:0] wdata;
    logic       winc;
    logic       rinc;
    logic [3:0] aethr;
    logic [3:0] afthr;
    logic       clr;
    logic [7:0] rdata;
    logic       rvalid;
    logic       wfull;
    logic       wfull_a;
    logic       rempty;
    logic       rempty_a;
    logic [4:0] level;
    logic       ovf;
    logic       udf;

    int checks = 0;
    int errors = 0;

    sfifo_lvl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_wdata         (wdata),
        .i_winc          (winc),
        .i_rinc          (rinc),
        .i_aempty_thr    (aethr),
        .i_afull_thr     (afthr),
        .i_clr_err       (clr),
        .o_rdata         (rdata),
        .o_rvalid        (rvalid),
        .o_wfull         (wfull),
        .o_wfull_almost  (wfull_a),
        .o_rempty        (rempty),
        .o_rempty_almost (rempty_a),
        .o_level         (level),
        .o_overflow      (ovf),
        .o_underflow     (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        wdata = d;
        winc  = 1'b1;
        tick();
        winc  = 1'b0;
    endtask

    task automatic clear_err();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Pop one word (optionally with a same-cycle write) and check the returned data.
    task automatic rd(input string tag, input logic w, input logic [7:0] wd, input logic [7:0] exp);
`ifdef SFIFO_FWFT_EN
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp));
`endif
        wdata = wd;
        winc  = w;
        rinc  = 1'b1;
        tick();
        winc  = 1'b0;
        rinc  = 1'b0;
`ifndef SFIFO_FWFT_EN
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp));
`endif
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;
    int         lvl;

    initial begin
        rst   = 1'b1;
        wdata = '0;
        winc  = 1'b0;
        rinc  = 1'b0;
        clr   = 1'b0;
        aethr = 4'd3;
        afthr = 4'd3;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_rempty_a", 32'(rempty_a), 32'd1);
        chk("rst_wfull", 32'(wfull), 32'd0);
        chk("rst_wfull_a", 32'(wfull_a), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_udf", 32'(udf), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
`ifndef SFIFO_FWFT_EN
        chk("rst_rdata", 32'(rdata), 32'd0);
`endif

`ifdef SFIFO_FWFT_EN
        // first word falls through without a read request
        wr(8'hA5);
        chk("fwft_rempty", 32'(rempty), 32'd0);
        chk("fwft_rvalid", 32'(rvalid), 32'd1);
        chk("fwft_rdata", 32'(rdata), 32'hA5);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("fwft_pop_rempty", 32'(rempty), 32'd1);
        chk("fwft_pop_rvalid", 32'(rvalid), 32'd0);
`endif

        // fill
        for (int i = 0; i < 16; i++) begin
            wr(8'(i));
            chk("fill_level", 32'(level), 32'(i + 1));
            chk("fill_wfull_a", 32'(wfull_a), 32'((i + 1) >= 13));
            chk("fill_wfull", 32'(wfull), 32'((i + 1) == 16));
            chk("fill_rempty_a", 32'(rempty_a), 32'((i + 1) <= 3));
        end
        wr(8'hFF);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        tick();
        chk("ovf_sticky", 32'(ovf), 32'd1);
        clear_err();
        chk("ovf_clr", 32'(ovf), 32'd0);

        // drain
        for (int i = 0; i < 16; i++) begin
            rd("drain", 1'b0, 8'h00, 8'(i));
            chk("drain_level", 32'(level), 32'(15 - i));
            chk("drain_rempty_a", 32'(rempty_a), 32'((15 - i) <= 3));
            chk("drain_rempty", 32'(rempty), 32'(i == 15));
        end
`ifndef SFIFO_FWFT_EN
        tick();
        chk("drain_rvalid_drop", 32'(rvalid), 32'd0);
`endif
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("udf_set", 32'(udf), 32'd1);
        chk("udf_rvalid", 32'(rvalid), 32'd0);
        chk("udf_level", 32'(level), 32'd0);
        clear_err();
        chk("udf_clr", 32'(udf), 32'd0);

        // simultaneous read/write at mid, full and empty
        for (int i = 0; i < 8; i++) begin
            wr(8'(8'h20 + i));
            q.push_back(8'(8'h20 + i));
        end
        exp_d = q.pop_front();
        rd("sim8", 1'b1, 8'h40, exp_d);
        q.push_back(8'h40);
        chk("sim8_level", 32'(level), 32'd8);
        for (int i = 0; i < 8; i++) begin
            wr(8'(8'h50 + i));
            q.push_back(8'(8'h50 + i));
        end
        chk("pre_full_level", 32'(level), 32'd16);
        exp_d = q.pop_front();
        rd("sim16", 1'b1, 8'hEE, exp_d);
        chk("sim16_level", 32'(level), 32'd15);
        chk("sim16_ovf", 32'(ovf), 32'd0);
        chk("sim16_wfull", 32'(wfull), 32'd0);
        while (q.size() > 0) begin
            exp_d = q.pop_front();
            rd("sim_drain", 1'b0, 8'h00, exp_d);
        end
        chk("sim_drain_level", 32'(level), 32'd0);
        wdata = 8'h99;
        winc  = 1'b1;
        rinc  = 1'b1;
        tick();
        winc  = 1'b0;
        rinc  = 1'b0;
        chk("sim0_level", 32'(level), 32'd1);
        chk("sim0_udf", 32'(udf), 32'd1);
`ifndef SFIFO_FWFT_EN
        chk("sim0_rvalid", 32'(rvalid), 32'd0);
`endif
        clear_err();
        rd("sim0_read", 1'b0, 8'h00, 8'h99);
        chk("sim0_read_level", 32'(level), 32'd0);

`ifndef SFIFO_FWFT_EN
        // wrap with random gaps, scoreboard tracking
        begin
            int  wr_cnt = 0;
            int  rd_cnt = 0;
            bit  exp_v  = 1'b0;
            logic [7:0] exp_r = '0;
            lvl = 0;
            for (int cyc = 0; cyc < 2000 && (wr_cnt < 40 || rd_cnt < 40); cyc++) begin
                bit wa;
                bit ra;
                winc  = (wr_cnt < 40) && ($urandom_range(0, 2) != 0);
                rinc  = (rd_cnt < 40) && ($urandom_range(0, 2) != 0);
                wdata = 8'($urandom_range(0, 255));
                wa = winc && (lvl < 16);
                ra = rinc && (lvl > 0);
                if (ra) begin
                    exp_r = q.pop_front();
                    rd_cnt++;
                    lvl--;
                end
                if (wa) begin
                    q.push_back(wdata);
                    wr_cnt++;
                    lvl++;
                end
                exp_v = ra;
                tick();
                winc = 1'b0;
                rinc = 1'b0;
                chk("wrap_level", 32'(level), 32'(lvl));
                chk("wrap_rvalid", 32'(rvalid), 32'(exp_v));
                if (exp_v) chk("wrap_rdata", 32'(rdata), 32'(exp_r));
            end
            chk("wrap_done_wr", 32'(wr_cnt), 32'd40);
            chk("wrap_done_rd", 32'(rd_cnt), 32'd40);
            clear_err();
        end
`endif

        // reset mid-operation discards contents
        for (int i = 0; i < 10; i++) wr(8'(8'h60 + i));
        chk("pre_rst_level", 32'(level), 32'd10);
        rst   = 1'b1;
        wdata = 8'hEE;
        winc  = 1'b1;
        tick();
        rst   = 1'b0;
        winc  = 1'b0;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_rempty", 32'(rempty), 32'd1);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_udf", 32'(udf), 32'd0);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        wr(8'h77);
        rd("post_rst", 1'b0, 8'h00, 8'h77);
        chk("post_rst_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
